// File: rtl/btb_pkg.sv
// Shared types and encodings for the BTB update path.
//   btb_upd_t     : one pending BTB write (pc, target, ins_type)
//   InsType*      : ins_type encodings, kept in step with the BTB itself
//   upd_needed()  : true when a resolved branch must be written back into the BTB
package btb_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [2:0]  ins_type;
  } btb_upd_t;

  localparam logic [2:0] InsTypeNone   = 3'b000;
  localparam logic [2:0] InsTypeBranch = 3'b001;
  localparam logic [2:0] InsTypeCall   = 3'b010;
  localparam logic [2:0] InsTypeReturn = 3'b011;

  // Only taken branches are written: the BTB has no invalidate path, so a
  // not-taken branch never needs an update even if the prediction was wrong.
  function automatic logic upd_needed(input logic        valid,
                                      input logic        taken,
                                      input logic [2:0]  pred_type,
                                      input logic [31:0] pred_target,
                                      input logic [2:0]  act_type,
                                      input logic [31:0] act_target);
    return valid & taken & ((pred_type != act_type) | (pred_target != act_target));
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending-update FIFO: up to two pushes and one pop per cycle, plus an in-place
// overwrite of the current tail entry.
//   clk_i, reset_i : clock, synchronous active-high reset (clears pointers and count)
//   pop_i          : drop the head entry
//   push_cnt_i     : number of entries to append (0..2), push0_i is older than push1_i
//   merge_i        : overwrite the tail entry (before this cycle's pushes) with merge_data_i
//   head_o         : oldest entry
//   tail_pc_o      : pc of the newest entry
//   count_o        : occupancy 0..Depth
// The caller guarantees no overflow/underflow; merge is only issued when the tail
// entry is not being popped.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     pop_i,
  input  logic [1:0]               push_cnt_i,
  input  btb_upd_t                 push0_i,
  input  btb_upd_t                 push1_i,
  input  logic                     merge_i,
  input  btb_upd_t                 merge_data_i,
  output btb_upd_t                 head_o,
  output logic [31:0]              tail_pc_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  btb_upd_t mem_q [Depth];
  ptr_t     rd_ptr_q, rd_ptr_d;
  ptr_t     wr_ptr_q, wr_ptr_d;
  cnt_t     count_q, count_d;
  ptr_t     tail_ptr;

  assign tail_ptr = wr_ptr_q - ptr_t'(1);

  always_comb begin
    rd_ptr_d = rd_ptr_q + ptr_t'(pop_i);
    wr_ptr_d = wr_ptr_q + ptr_t'(push_cnt_i);
    count_d  = count_q - cnt_t'(pop_i) + cnt_t'(push_cnt_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (merge_i) begin
      mem_q[tail_ptr] <= merge_data_i;
    end
    if (push_cnt_i != 2'd0) begin
      mem_q[wr_ptr_q] <= push0_i;
    end
    if (push_cnt_i == 2'd2) begin
      mem_q[wr_ptr_q + ptr_t'(1)] <= push1_i;
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign tail_pc_o = mem_q[tail_ptr].pc;
  assign count_o   = count_q;

endmodule

// File: rtl/btb_update_gen.sv
// BTB update producer. Qualifies resolved branches from the two EX lanes, buffers
// the ones needing a BTB write and issues one registered update per cycle.
//   clk, reset            : clock, synchronous active-high reset
//   ex_*_0 / ex_*_1       : resolved branch from lane 0 (older) and lane 1
//   branch_mistaken       : one-cycle write strobe to the BTB (no back-pressure)
//   ins_type_w, wrong_pc,
//   right_target          : update payload, held when branch_mistaken is low
//   drop_cnt              : saturating count of updates lost to FIFO overflow
module btb_update_gen
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid_0,
  input  logic [31:0]     ex_pc_0,
  input  logic [2:0]      ex_pred_type_0,
  input  logic [31:0]     ex_pred_target_0,
  input  logic            ex_taken_0,
  input  logic [31:0]     ex_target_0,
  input  logic [2:0]      ex_type_0,
  input  logic            ex_valid_1,
  input  logic [31:0]     ex_pc_1,
  input  logic [2:0]      ex_pred_type_1,
  input  logic [31:0]     ex_pred_target_1,
  input  logic            ex_taken_1,
  input  logic [31:0]     ex_target_1,
  input  logic [2:0]      ex_type_1,
  output logic            branch_mistaken,
  output logic [2:0]      ins_type_w,
  output logic [31:0]     wrong_pc,
  output logic [31:0]     right_target,
  output logic [CNTW-1:0] drop_cnt
);

  localparam int unsigned CntFW = $clog2(DEPTH) + 1;
  typedef logic [CntFW-1:0] fcnt_t;

  logic     q0, q1, l0_keep;
  btb_upd_t lane0_upd, lane1_upd;

  btb_upd_t    fifo_head;
  logic [31:0] fifo_tail_pc;
  fcnt_t       fifo_count;

  btb_upd_t nw_0, nw_1, out_upd, merge_upd;
  logic [1:0] n_new, push_cnt, drop_n;
  logic     out_vld, pop, merge;
  fcnt_t    remain, free;

  logic            bm_q;
  btb_upd_t        upd_q, upd_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNTW:0]   drop_sum;

  assign q0 = upd_needed(ex_valid_0, ex_taken_0, ex_pred_type_0, ex_pred_target_0,
                         ex_type_0, ex_target_0);
  assign q1 = upd_needed(ex_valid_1, ex_taken_1, ex_pred_type_1, ex_pred_target_1,
                         ex_type_1, ex_target_1);
  // Same pc on both lanes: the younger resolution wins, the older is silently discarded.
  assign l0_keep = q0 & ~(q1 & (ex_pc_0 == ex_pc_1));

  assign lane0_upd = '{pc: ex_pc_0, target: ex_target_0, ins_type: ex_type_0};
  assign lane1_upd = '{pc: ex_pc_1, target: ex_target_1, ins_type: ex_type_1};

  always_comb begin
    nw_0      = lane0_upd;
    nw_1      = lane1_upd;
    n_new     = 2'd0;
    out_vld   = 1'b0;
    out_upd   = '0;
    pop       = 1'b0;
    merge     = 1'b0;
    merge_upd = '0;
    remain    = fifo_count;
    free      = '0;
    push_cnt  = 2'd0;
    drop_n    = 2'd0;

    // Compact the surviving lanes into nw_0 (older) / nw_1.
    if (l0_keep) begin
      n_new = q1 ? 2'd2 : 2'd1;
    end else if (q1) begin
      nw_0  = lane1_upd;
      n_new = 2'd1;
    end

    // Oldest candidate goes to the output register; lanes bypass an empty FIFO.
    if (fifo_count != '0) begin
      pop     = 1'b1;
      out_vld = 1'b1;
      out_upd = fifo_head;
      remain  = fifo_count - fcnt_t'(1);
    end else if (n_new != 2'd0) begin
      out_vld = 1'b1;
      out_upd = nw_0;
      nw_0    = nw_1;
      n_new   = n_new - 2'd1;
    end

    // Refresh a still-queued tail with the same pc instead of taking a new slot.
    if ((n_new != 2'd0) && (remain != '0) && (nw_0.pc == fifo_tail_pc)) begin
      merge     = 1'b1;
      merge_upd = nw_0;
      nw_0      = nw_1;
      n_new     = n_new - 2'd1;
    end

    // Whatever does not fit is dropped, newest first.
    free = fcnt_t'(DEPTH) - remain;
    if (fcnt_t'(n_new) <= free) begin
      push_cnt = n_new;
    end else begin
      push_cnt = free[1:0];
    end
    drop_n = n_new - push_cnt;
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + {{(CNTW - 1){1'b0}}, drop_n};
    drop_cnt_d = drop_sum[CNTW] ? {CNTW{1'b1}} : drop_sum[CNTW-1:0];
    upd_d      = out_vld ? out_upd : upd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bm_q       <= 1'b0;
      upd_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      bm_q       <= out_vld;
      upd_q      <= upd_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  btb_upd_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .reset_i      (reset),
    .pop_i        (pop),
    .push_cnt_i   (push_cnt),
    .push0_i      (nw_0),
    .push1_i      (nw_1),
    .merge_i      (merge),
    .merge_data_i (merge_upd),
    .head_o       (fifo_head),
    .tail_pc_o    (fifo_tail_pc),
    .count_o      (fifo_count)
  );

  assign branch_mistaken = bm_q;
  assign ins_type_w      = upd_q.ins_type;
  assign wrong_pc        = upd_q.pc;
  assign right_target    = upd_q.target;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_btb_update_gen.sv
module tb_btb_update_gen;
  import btb_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid       [2];
  logic [31:0] ex_pc          [2];
  logic [2:0]  ex_pred_type   [2];
  logic [31:0] ex_pred_target [2];
  logic        ex_taken       [2];
  logic [31:0] ex_target      [2];
  logic [2:0]  ex_type        [2];

  logic            branch_mistaken;
  logic [2:0]      ins_type_w;
  logic [31:0]     wrong_pc;
  logic [31:0]     right_target;
  logic [CntW-1:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse log filled by the monitor; cyc counts rising edges.
  int          cyc = 0;
  logic [31:0] log_pc  [$];
  logic [31:0] log_tgt [$];
  logic [2:0]  log_type[$];
  int          log_cyc [$];

  btb_update_gen #(
    .DEPTH (Depth),
    .CNTW  (CntW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid_0       (ex_valid[0]),
    .ex_pc_0          (ex_pc[0]),
    .ex_pred_type_0   (ex_pred_type[0]),
    .ex_pred_target_0 (ex_pred_target[0]),
    .ex_taken_0       (ex_taken[0]),
    .ex_target_0      (ex_target[0]),
    .ex_type_0        (ex_type[0]),
    .ex_valid_1       (ex_valid[1]),
    .ex_pc_1          (ex_pc[1]),
    .ex_pred_type_1   (ex_pred_type[1]),
    .ex_pred_target_1 (ex_pred_target[1]),
    .ex_taken_1       (ex_taken[1]),
    .ex_target_1      (ex_target[1]),
    .ex_type_1        (ex_type[1]),
    .branch_mistaken  (branch_mistaken),
    .ins_type_w       (ins_type_w),
    .wrong_pc         (wrong_pc),
    .right_target     (right_target),
    .drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (branch_mistaken === 1'b1) begin
      log_pc.push_back(wrong_pc);
      log_tgt.push_back(right_target);
      log_type.push_back(ins_type_w);
      log_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_lanes();
    for (int i = 0; i < 2; i++) begin
      ex_valid[i]       = 1'b0;
      ex_pc[i]          = 32'h0;
      ex_pred_type[i]   = InsTypeNone;
      ex_pred_target[i] = 32'h0;
      ex_taken[i]       = 1'b0;
      ex_target[i]      = 32'h0;
      ex_type[i]        = InsTypeNone;
    end
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [2:0] ptype, input logic [31:0] ptgt,
                          input logic taken, input logic [2:0] typ);
    ex_valid[i]       = 1'b1;
    ex_pc[i]          = pc;
    ex_pred_type[i]   = ptype;
    ex_pred_target[i] = ptgt;
    ex_taken[i]       = taken;
    ex_target[i]      = tgt;
    ex_type[i]        = typ;
  endtask

  // Taken branch that missed in the BTB.
  task automatic miss(input int i, input logic [31:0] pc, input logic [31:0] tgt);
    set_lane(i, pc, tgt, InsTypeNone, 32'h0, 1'b1, InsTypeBranch);
  endtask

  task automatic clear_log();
    log_pc.delete();
    log_tgt.delete();
    log_type.delete();
    log_cyc.delete();
  endtask

  task automatic drain();
    idle_lanes();
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int late;
    logic [31:0] exp_pc [$];
    logic [31:0] exp_tgt[$];

    // Reset held 3 cycles with both lanes presenting misses.
    reset = 1'b1;
    miss(0, 32'h1c00_0100, 32'h1c00_0200);
    miss(1, 32'h1c00_0180, 32'h1c00_0280);
    tick();
    check_eq("rst_bm", 64'(branch_mistaken), 64'd0);
    check_eq("rst_pc", 64'(wrong_pc), 64'd0);
    check_eq("rst_tgt", 64'(right_target), 64'd0);
    check_eq("rst_type", 64'(ins_type_w), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    tick();
    tick();
    check_eq("rst3_bm", 64'(branch_mistaken), 64'd0);
    reset = 1'b0;
    idle_lanes();
    tick();
    check_eq("post_rst_bm", 64'(branch_mistaken), 64'd0);
    check_eq("post_rst_pc", 64'(wrong_pc), 64'd0);
    check_eq("post_rst_tgt", 64'(right_target), 64'd0);
    drain();
    check_eq("post_rst_pulses", 64'(log_pc.size()), 64'd0);

    // Single miss: bypass to the output one cycle later, one-cycle pulse.
    clear_log();
    miss(0, 32'h1c00_0100, 32'h1c00_0200);
    tick();
    idle_lanes();
    check_eq("single_bm", 64'(branch_mistaken), 64'd1);
    check_eq("single_pc", 64'(wrong_pc), 64'h1c00_0100);
    check_eq("single_tgt", 64'(right_target), 64'h1c00_0200);
    check_eq("single_type", 64'(ins_type_w), 64'(InsTypeBranch));
    tick();
    check_eq("single_pulse_end", 64'(branch_mistaken), 64'd0);
    check_eq("single_hold_pc", 64'(wrong_pc), 64'h1c00_0100);

    // Correct prediction, then a not-taken branch with a wrong prediction.
    clear_log();
    set_lane(0, 32'h1c00_0300, 32'h1c00_0400, InsTypeBranch, 32'h1c00_0400, 1'b1,
             InsTypeBranch);
    set_lane(1, 32'h1c00_0310, 32'h1c00_0500, InsTypeCall, 32'h1c00_0500, 1'b1,
             InsTypeCall);
    tick();
    idle_lanes();
    tick();
    check_eq("correct_bm", 64'(branch_mistaken), 64'd0);
    set_lane(0, 32'h1c00_0320, 32'h1c00_0600, InsTypeNone, 32'h0, 1'b0, InsTypeBranch);
    tick();
    idle_lanes();
    tick();
    check_eq("nottaken_bm", 64'(branch_mistaken), 64'd0);
    drain();
    check_eq("no_update_pulses", 64'(log_pc.size()), 64'd0);

    // Dual burst: 6 pulses in consecutive cycles.
    clear_log();
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      miss(0, 32'h100, 32'h1100);
      miss(1, 32'h200, 32'h1200);
      tick();
    end
    drain();
    check_eq("burst_count", 64'(log_pc.size()), 64'd6);
    check_eq("burst_first_cyc", 64'(log_cyc[0]), 64'(c0 + 1));
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("burst_pc%0d", k), 64'(log_pc[k]), (k % 2 == 0) ? 64'h100 : 64'h200);
      check_eq($sformatf("burst_cyc%0d", k), 64'(log_cyc[k]), 64'(c0 + 1 + k));
    end
    check_eq("burst_drop", 64'(drop_cnt), 64'd0);

    // Overflow: 8 cycles of 2 distinct updates; lane 1 is lost in cycles 5..8.
    clear_log();
    exp_pc.delete();
    exp_tgt.delete();
    for (int k = 0; k < 8; k++) begin
      miss(0, 32'h2000 + 32'(16 * k), 32'h3000 + 32'(16 * k));
      miss(1, 32'h2008 + 32'(16 * k), 32'h3008 + 32'(16 * k));
      exp_pc.push_back(32'h2000 + 32'(16 * k));
      exp_tgt.push_back(32'h3000 + 32'(16 * k));
      if (k < 4) begin
        exp_pc.push_back(32'h2008 + 32'(16 * k));
        exp_tgt.push_back(32'h3008 + 32'(16 * k));
      end
      tick();
    end
    c0 = cyc;
    check_eq("ovf_drop_now", 64'(drop_cnt), 64'd4);
    drain();
    check_eq("ovf_count", 64'(log_pc.size()), 64'd12);
    late = 0;
    foreach (log_cyc[k]) begin
      if (log_cyc[k] >= c0) late++;
    end
    check_eq("ovf_held_back", 64'(late), 64'(Depth + 1));
    for (int k = 0; k < 12; k++) begin
      check_eq($sformatf("ovf_pc%0d", k), 64'(log_pc[k]), 64'(exp_pc[k]));
      check_eq($sformatf("ovf_tgt%0d", k), 64'(log_tgt[k]), 64'(exp_tgt[k]));
    end
    check_eq("ovf_drop", 64'(drop_cnt), 64'd4);

    // Reset mid-burst with the FIFO full and lanes active.
    for (int k = 0; k < 4; k++) begin
      miss(0, 32'h5000 + 32'(16 * k), 32'h6000);
      miss(1, 32'h5008 + 32'(16 * k), 32'h6008);
      tick();
    end
    reset = 1'b1;
    tick();
    check_eq("midrst_bm", 64'(branch_mistaken), 64'd0);
    check_eq("midrst_pc", 64'(wrong_pc), 64'd0);
    check_eq("midrst_drop", 64'(drop_cnt), 64'd0);
    reset = 1'b0;
    idle_lanes();
    clear_log();
    tick();
    check_eq("midrst_post_bm", 64'(branch_mistaken), 64'd0);
    drain();
    check_eq("midrst_pulses", 64'(log_pc.size()), 64'd0);

    // Same-cycle dedup: younger lane's target wins.
    clear_log();
    set_lane(0, 32'h300, 32'hA, InsTypeNone, 32'h0, 1'b1, InsTypeBranch);
    set_lane(1, 32'h300, 32'hB, InsTypeNone, 32'h0, 1'b1, InsTypeCall);
    tick();
    drain();
    check_eq("dedup_count", 64'(log_pc.size()), 64'd1);
    check_eq("dedup_pc", 64'(log_pc[0]), 64'h300);
    check_eq("dedup_tgt", 64'(log_tgt[0]), 64'hB);
    check_eq("dedup_type", 64'(log_type[0]), 64'(InsTypeCall));
    check_eq("dedup_drop", 64'(drop_cnt), 64'd0);

    // Tail merge: 0x400 queued behind 0x3a0, new 0x400 refreshes it in place.
    clear_log();
    miss(0, 32'h380, 32'h1380);
    miss(1, 32'h390, 32'h1390);
    tick();
    miss(0, 32'h3a0, 32'h13a0);
    miss(1, 32'h400, 32'hD00);
    tick();
    idle_lanes();
    miss(0, 32'h400, 32'hC);
    tick();
    drain();
    check_eq("merge_count", 64'(log_pc.size()), 64'd4);
    check_eq("merge_pc0", 64'(log_pc[0]), 64'h380);
    check_eq("merge_pc1", 64'(log_pc[1]), 64'h390);
    check_eq("merge_pc2", 64'(log_pc[2]), 64'h3a0);
    check_eq("merge_pc3", 64'(log_pc[3]), 64'h400);
    check_eq("merge_tgt3", 64'(log_tgt[3]), 64'hC);
    check_eq("merge_drop", 64'(drop_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
